// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared RV32I decode definitions used by core_decode and core_imm_gen:
//   - major opcode constants (OPC_*)
//   - funct3 / funct7 constants (F3_*, F7_*)
//   - immediate-format enum (FMT_I, FMT_S, FMT_B, FMT_R)
//   - bit positions of each one-hot operation strobe in the decoded vector
// ---------------------------------------------------------------------------
package core_pkg;

    // Major opcodes (INST[6:0]); every legal one ends in 2'b11
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;

    // ALU funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load / store funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Single-precision FP load/store width
    localparam logic [2:0] F3_FP_W = 3'b010;

    // funct7
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        FMT_I = 2'd0,
        FMT_S = 2'd1,
        FMT_B = 2'd2,
        FMT_R = 2'd3
    } imm_fmt_e;

    // Strobe positions inside the decoded one-hot vector
    localparam int unsigned NUM_STB  = 35;
    localparam int unsigned STB_ADDI  = 0;
    localparam int unsigned STB_SLTI  = 1;
    localparam int unsigned STB_SLTIU = 2;
    localparam int unsigned STB_XORI  = 3;
    localparam int unsigned STB_ORI   = 4;
    localparam int unsigned STB_ANDI  = 5;
    localparam int unsigned STB_SLLI  = 6;
    localparam int unsigned STB_SRLI  = 7;
    localparam int unsigned STB_SRAI  = 8;
    localparam int unsigned STB_ADD   = 9;
    localparam int unsigned STB_SUB   = 10;
    localparam int unsigned STB_SLL   = 11;
    localparam int unsigned STB_SLT   = 12;
    localparam int unsigned STB_SLTU  = 13;
    localparam int unsigned STB_XOR   = 14;
    localparam int unsigned STB_SRL   = 15;
    localparam int unsigned STB_SRA   = 16;
    localparam int unsigned STB_OR    = 17;
    localparam int unsigned STB_AND   = 18;
    localparam int unsigned STB_BEQ   = 19;
    localparam int unsigned STB_BNE   = 20;
    localparam int unsigned STB_BLT   = 21;
    localparam int unsigned STB_BGE   = 22;
    localparam int unsigned STB_BLTU  = 23;
    localparam int unsigned STB_BGEU  = 24;
    localparam int unsigned STB_LB    = 25;
    localparam int unsigned STB_LH    = 26;
    localparam int unsigned STB_LW    = 27;
    localparam int unsigned STB_LBU   = 28;
    localparam int unsigned STB_LHU   = 29;
    localparam int unsigned STB_SB    = 30;
    localparam int unsigned STB_SH    = 31;
    localparam int unsigned STB_SW    = 32;
    localparam int unsigned STB_FLW   = 33;
    localparam int unsigned STB_FSW   = 34;

endpackage

// File: rtl/core_imm_gen.sv
// ---------------------------------------------------------------------------
// core_imm_gen
// Combinational immediate formatter.
//   inst  in  32  instruction word
//   fmt   in   2  immediate format (FMT_I / FMT_S / FMT_B / FMT_R)
//   imm   out 32  sign-extended immediate (0 for FMT_R)
// ---------------------------------------------------------------------------
module core_imm_gen
    import core_pkg::*;
(
    input  logic [31:0] inst,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    // Opcode, funct3 and rs1 fields never contribute to an immediate
    logic unused_bits_s;
    assign unused_bits_s = ^{inst[19:12], inst[6:0]};

    // Select and sign-extend the immediate for the requested format
    always_comb begin
        imm = 32'd0;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_R:   imm = 32'd0;
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/core_decode.sv
// ---------------------------------------------------------------------------
// core_decode
// Registered RV32I decode stage between fetch and core_alu, one pipeline
// register deep with valid/ready handshakes on both sides.
//   CLK, RST_N            clock, synchronous active-low reset
//   INST_VALID/INST/PC_IN fetch side; INST_READY is combinational
//   FLUSH                 drops the held and any incoming instruction
//   OUT_VALID/OUT_READY   downstream handshake
//   I_*                   one-hot operation strobes (all 0 when !OUT_VALID)
//   RS1/RS2/RD_ADDR, IMM  register indices and sign-extended immediate
//   PC_OUT, ILLEGAL       PC of the bundle, undecodable-instruction flag
// Build option: define CORE_DECODE_FPU_EN to decode FLW/FSW; otherwise both
// FP opcodes are illegal and I_FLW/I_FSW are tied to 0.
// ---------------------------------------------------------------------------
module core_decode
    import core_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        INST_VALID,
    input  logic [31:0] INST,
    input  logic [31:0] PC_IN,
    output logic        INST_READY,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI,
    output logic        I_SLLI, I_SRLI, I_SRAI,
    output logic        I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR,
    output logic        I_SRL, I_SRA, I_OR, I_AND,
    output logic        I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
    output logic        I_LB, I_LH, I_LW, I_LBU, I_LHU,
    output logic        I_SB, I_SH, I_SW,
    output logic        I_FLW, I_FSW,
    output logic [4:0]  RS1_ADDR,
    output logic [4:0]  RS2_ADDR,
    output logic [4:0]  RD_ADDR,
    output logic [31:0] IMM,
    output logic [31:0] PC_OUT,
    output logic        ILLEGAL
);

`ifdef CORE_DECODE_FPU_EN
    localparam logic FPU_EN = 1'b1;
`else
    localparam logic FPU_EN = 1'b0;
`endif

    logic [6:0]         opcode_s;
    logic [2:0]         f3_s;
    logic [6:0]         f7_s;
    logic [NUM_STB-1:0] stb_s;
    logic               illegal_s;
    imm_fmt_e           fmt_s;
    imm_fmt_e           fmt_eff_s;
    logic [31:0]        imm_s;
    logic [4:0]         rs1_s, rs2_s, rd_s;
    logic               accept_s;

    logic               out_valid_d, out_valid_q;
    logic [NUM_STB-1:0] stb_d, stb_q;
    logic               illegal_d, illegal_q;
    logic [31:0]        imm_d, imm_q;
    logic [4:0]         rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [31:0]        pc_d, pc_q;

    assign opcode_s = INST[6:0];
    assign f3_s     = INST[14:12];
    assign f7_s     = INST[31:25];

    // Opcode/funct decode into a one-hot strobe vector plus immediate format
    always_comb begin
        stb_s     = {NUM_STB{1'b0}};
        illegal_s = 1'b0;
        fmt_s     = FMT_R;
        case (opcode_s)
            OPC_OP_IMM: begin
                fmt_s = FMT_I;
                case (f3_s)
                    F3_ADD_SUB: stb_s[STB_ADDI]  = 1'b1;
                    F3_SLT:     stb_s[STB_SLTI]  = 1'b1;
                    F3_SLTU:    stb_s[STB_SLTIU] = 1'b1;
                    F3_XOR:     stb_s[STB_XORI]  = 1'b1;
                    F3_OR:      stb_s[STB_ORI]   = 1'b1;
                    F3_AND:     stb_s[STB_ANDI]  = 1'b1;
                    F3_SLL: begin
                        if (f7_s == F7_BASE) stb_s[STB_SLLI] = 1'b1;
                        else                 illegal_s = 1'b1;
                    end
                    F3_SRL_SRA: begin
                        if (f7_s == F7_BASE)     stb_s[STB_SRLI] = 1'b1;
                        else if (f7_s == F7_ALT) stb_s[STB_SRAI] = 1'b1;
                        else                     illegal_s = 1'b1;
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_OP: begin
                fmt_s = FMT_R;
                if (f7_s == F7_BASE) begin
                    case (f3_s)
                        F3_ADD_SUB: stb_s[STB_ADD]  = 1'b1;
                        F3_SLL:     stb_s[STB_SLL]  = 1'b1;
                        F3_SLT:     stb_s[STB_SLT]  = 1'b1;
                        F3_SLTU:    stb_s[STB_SLTU] = 1'b1;
                        F3_XOR:     stb_s[STB_XOR]  = 1'b1;
                        F3_SRL_SRA: stb_s[STB_SRL]  = 1'b1;
                        F3_OR:      stb_s[STB_OR]   = 1'b1;
                        F3_AND:     stb_s[STB_AND]  = 1'b1;
                        default:    illegal_s = 1'b1;
                    endcase
                end else if (f7_s == F7_ALT) begin
                    // Only ADD and SRL have an alternate (SUB/SRA) encoding
                    case (f3_s)
                        F3_ADD_SUB: stb_s[STB_SUB] = 1'b1;
                        F3_SRL_SRA: stb_s[STB_SRA] = 1'b1;
                        default:    illegal_s = 1'b1;
                    endcase
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_BRANCH: begin
                fmt_s = FMT_B;
                case (f3_s)
                    F3_BEQ:  stb_s[STB_BEQ]  = 1'b1;
                    F3_BNE:  stb_s[STB_BNE]  = 1'b1;
                    F3_BLT:  stb_s[STB_BLT]  = 1'b1;
                    F3_BGE:  stb_s[STB_BGE]  = 1'b1;
                    F3_BLTU: stb_s[STB_BLTU] = 1'b1;
                    F3_BGEU: stb_s[STB_BGEU] = 1'b1;
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                fmt_s = FMT_I;
                case (f3_s)
                    F3_LB:   stb_s[STB_LB]  = 1'b1;
                    F3_LH:   stb_s[STB_LH]  = 1'b1;
                    F3_LW:   stb_s[STB_LW]  = 1'b1;
                    F3_LBU:  stb_s[STB_LBU] = 1'b1;
                    F3_LHU:  stb_s[STB_LHU] = 1'b1;
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_STORE: begin
                fmt_s = FMT_S;
                case (f3_s)
                    F3_SB:   stb_s[STB_SB] = 1'b1;
                    F3_SH:   stb_s[STB_SH] = 1'b1;
                    F3_SW:   stb_s[STB_SW] = 1'b1;
                    default: illegal_s = 1'b1;
                endcase
            end
`ifdef CORE_DECODE_FPU_EN
            OPC_LOAD_FP: begin
                fmt_s = FMT_I;
                if (f3_s == F3_FP_W) stb_s[STB_FLW] = 1'b1;
                else                 illegal_s = 1'b1;
            end
            OPC_STORE_FP: begin
                fmt_s = FMT_S;
                if (f3_s == F3_FP_W) stb_s[STB_FSW] = 1'b1;
                else                 illegal_s = 1'b1;
            end
`endif
            default: illegal_s = 1'b1;
        endcase
    end

    // An illegal bundle carries zero immediate and zero register fields so
    // downstream never sees stale-looking operands
    assign fmt_eff_s = illegal_s ? FMT_R : fmt_s;
    assign rs1_s     = illegal_s ? 5'd0 : INST[19:15];
    assign rs2_s     = (illegal_s || (fmt_s == FMT_I)) ? 5'd0 : INST[24:20];
    assign rd_s      = (illegal_s || (fmt_s == FMT_S) || (fmt_s == FMT_B)) ? 5'd0 : INST[11:7];

    core_imm_gen u_imm_gen (
        .inst (INST),
        .fmt  (fmt_eff_s),
        .imm  (imm_s)
    );

    assign INST_READY = !out_valid_q || OUT_READY;
    assign accept_s   = INST_VALID && INST_READY;

    // Output-register next state: flush > accept > drain > hold
    always_comb begin
        out_valid_d = out_valid_q;
        stb_d       = stb_q;
        illegal_d   = illegal_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        pc_d        = pc_q;
        if (FLUSH) begin
            out_valid_d = 1'b0;
            stb_d       = {NUM_STB{1'b0}};
            illegal_d   = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            stb_d       = stb_s;
            illegal_d   = illegal_s;
            imm_d       = imm_s;
            rs1_d       = rs1_s;
            rs2_d       = rs2_s;
            rd_d        = rd_s;
            pc_d        = PC_IN;
        end else if (OUT_READY) begin
            out_valid_d = 1'b0;
            stb_d       = {NUM_STB{1'b0}};
            illegal_d   = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
            stb_d       = stb_q;
            illegal_d   = illegal_q;
        end
    end

    // Bundle register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            stb_q       <= {NUM_STB{1'b0}};
            illegal_q   <= 1'b0;
            imm_q       <= 32'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            pc_q        <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            stb_q       <= stb_d;
            illegal_q   <= illegal_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            pc_q        <= pc_d;
        end
    end

    assign OUT_VALID = out_valid_q;
    assign ILLEGAL   = illegal_q;
    assign IMM       = imm_q;
    assign RS1_ADDR  = rs1_q;
    assign RS2_ADDR  = rs2_q;
    assign RD_ADDR   = rd_q;
    assign PC_OUT    = pc_q;

    assign I_ADDI  = stb_q[STB_ADDI];
    assign I_SLTI  = stb_q[STB_SLTI];
    assign I_SLTIU = stb_q[STB_SLTIU];
    assign I_XORI  = stb_q[STB_XORI];
    assign I_ORI   = stb_q[STB_ORI];
    assign I_ANDI  = stb_q[STB_ANDI];
    assign I_SLLI  = stb_q[STB_SLLI];
    assign I_SRLI  = stb_q[STB_SRLI];
    assign I_SRAI  = stb_q[STB_SRAI];
    assign I_ADD   = stb_q[STB_ADD];
    assign I_SUB   = stb_q[STB_SUB];
    assign I_SLL   = stb_q[STB_SLL];
    assign I_SLT   = stb_q[STB_SLT];
    assign I_SLTU  = stb_q[STB_SLTU];
    assign I_XOR   = stb_q[STB_XOR];
    assign I_SRL   = stb_q[STB_SRL];
    assign I_SRA   = stb_q[STB_SRA];
    assign I_OR    = stb_q[STB_OR];
    assign I_AND   = stb_q[STB_AND];
    assign I_BEQ   = stb_q[STB_BEQ];
    assign I_BNE   = stb_q[STB_BNE];
    assign I_BLT   = stb_q[STB_BLT];
    assign I_BGE   = stb_q[STB_BGE];
    assign I_BLTU  = stb_q[STB_BLTU];
    assign I_BGEU  = stb_q[STB_BGEU];
    assign I_LB    = stb_q[STB_LB];
    assign I_LH    = stb_q[STB_LH];
    assign I_LW    = stb_q[STB_LW];
    assign I_LBU   = stb_q[STB_LBU];
    assign I_LHU   = stb_q[STB_LHU];
    assign I_SB    = stb_q[STB_SB];
    assign I_SH    = stb_q[STB_SH];
    assign I_SW    = stb_q[STB_SW];
    // Gated so the disabled build ties the FP strobes to a constant 0
    assign I_FLW   = stb_q[STB_FLW] & FPU_EN;
    assign I_FSW   = stb_q[STB_FSW] & FPU_EN;

endmodule

// File: tb/tb_core_decode.sv
// ---------------------------------------------------------------------------
// tb_core_decode
// Self-checking bench for core_decode: directed cases followed by random
// traffic compared against a table-driven instruction model and a
// transaction-level model of the one-deep output register.
// ---------------------------------------------------------------------------
module tb_core_decode;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        INST_VALID = 1'b0;
    logic [31:0] INST = 32'd0;
    logic [31:0] PC_IN = 32'd0;
    logic        INST_READY;
    logic        FLUSH = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic        I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI;
    logic        I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND;
    logic        I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU;
    logic        I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW, I_FLW, I_FSW;
    logic [4:0]  RS1_ADDR, RS2_ADDR, RD_ADDR;
    logic [31:0] IMM, PC_OUT;
    logic        ILLEGAL;

    always #5 CLK = ~CLK;

    core_decode dut (
        .CLK(CLK), .RST_N(RST_N), .INST_VALID(INST_VALID), .INST(INST), .PC_IN(PC_IN),
        .INST_READY(INST_READY), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .I_ADDI(I_ADDI), .I_SLTI(I_SLTI), .I_SLTIU(I_SLTIU), .I_XORI(I_XORI), .I_ORI(I_ORI),
        .I_ANDI(I_ANDI), .I_SLLI(I_SLLI), .I_SRLI(I_SRLI), .I_SRAI(I_SRAI),
        .I_ADD(I_ADD), .I_SUB(I_SUB), .I_SLL(I_SLL), .I_SLT(I_SLT), .I_SLTU(I_SLTU),
        .I_XOR(I_XOR), .I_SRL(I_SRL), .I_SRA(I_SRA), .I_OR(I_OR), .I_AND(I_AND),
        .I_BEQ(I_BEQ), .I_BNE(I_BNE), .I_BLT(I_BLT), .I_BGE(I_BGE), .I_BLTU(I_BLTU),
        .I_BGEU(I_BGEU), .I_LB(I_LB), .I_LH(I_LH), .I_LW(I_LW), .I_LBU(I_LBU), .I_LHU(I_LHU),
        .I_SB(I_SB), .I_SH(I_SH), .I_SW(I_SW), .I_FLW(I_FLW), .I_FSW(I_FSW),
        .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR), .RD_ADDR(RD_ADDR),
        .IMM(IMM), .PC_OUT(PC_OUT), .ILLEGAL(ILLEGAL)
    );

    // Strobes gathered in table order: index k of the model table is bit k
    logic [34:0] got_stb;
    assign got_stb = {I_FSW, I_FLW, I_SW, I_SH, I_SB, I_LHU, I_LBU, I_LW, I_LH, I_LB,
                      I_BGEU, I_BLTU, I_BGE, I_BLT, I_BNE, I_BEQ,
                      I_AND, I_OR, I_SRA, I_SRL, I_XOR, I_SLTU, I_SLT, I_SLL, I_SUB, I_ADD,
                      I_SRAI, I_SRLI, I_SLLI, I_ANDI, I_ORI, I_XORI, I_SLTIU, I_SLTI, I_ADDI};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instruction table: opcode, funct3, funct7 (-1 = don't care), format
    // format codes: 0=I 1=S 2=B 3=R
    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        int         f7;
        int         fmt;
    } ent_t;
    ent_t tbl[35];

`ifdef CORE_DECODE_FPU_EN
    localparam int N_ENT = 35;
`else
    localparam int N_ENT = 33;
`endif

    task automatic add(input int k, input logic [6:0] opc, input logic [2:0] f3,
                       input int f7, input int fmt);
        tbl[k].opc = opc; tbl[k].f3 = f3; tbl[k].f7 = f7; tbl[k].fmt = fmt;
    endtask

    task automatic build_table();
        logic [6:0] oi, oo, ob, ol, os;
        oi = 7'b0010011; oo = 7'b0110011; ob = 7'b1100011; ol = 7'b0000011; os = 7'b0100011;
        add(0, oi, 3'd0, -1, 0);   add(1, oi, 3'd2, -1, 0);   add(2, oi, 3'd3, -1, 0);
        add(3, oi, 3'd4, -1, 0);   add(4, oi, 3'd6, -1, 0);   add(5, oi, 3'd7, -1, 0);
        add(6, oi, 3'd1, 0, 0);    add(7, oi, 3'd5, 0, 0);    add(8, oi, 3'd5, 32, 0);
        add(9, oo, 3'd0, 0, 3);    add(10, oo, 3'd0, 32, 3);  add(11, oo, 3'd1, 0, 3);
        add(12, oo, 3'd2, 0, 3);   add(13, oo, 3'd3, 0, 3);   add(14, oo, 3'd4, 0, 3);
        add(15, oo, 3'd5, 0, 3);   add(16, oo, 3'd5, 32, 3);  add(17, oo, 3'd6, 0, 3);
        add(18, oo, 3'd7, 0, 3);
        add(19, ob, 3'd0, -1, 2);  add(20, ob, 3'd1, -1, 2);  add(21, ob, 3'd4, -1, 2);
        add(22, ob, 3'd5, -1, 2);  add(23, ob, 3'd6, -1, 2);  add(24, ob, 3'd7, -1, 2);
        add(25, ol, 3'd0, -1, 0);  add(26, ol, 3'd1, -1, 0);  add(27, ol, 3'd2, -1, 0);
        add(28, ol, 3'd4, -1, 0);  add(29, ol, 3'd5, -1, 0);
        add(30, os, 3'd0, -1, 1);  add(31, os, 3'd1, -1, 1);  add(32, os, 3'd2, -1, 1);
        add(33, 7'b0000111, 3'd2, -1, 0);
        add(34, 7'b0100111, 3'd2, -1, 1);
    endtask

    // Expected bundle currently held by the stage
    logic        exp_valid = 1'b0;
    int          exp_idx = -1;
    logic [31:0] exp_imm, exp_pc;
    logic [4:0]  exp_rs1, exp_rs2, exp_rd;

    task automatic model_decode(input logic [31:0] ins, output int idx, output logic [31:0] imm,
                                output logic [4:0] rs1, output logic [4:0] rs2,
                                output logic [4:0] rd);
        int fmt;
        idx = -1;
        fmt = 3;
        for (int k = 0; k < N_ENT; k++) begin
            if (ins[6:0] == tbl[k].opc && ins[14:12] == tbl[k].f3 &&
                (tbl[k].f7 < 0 || int'(ins[31:25]) == tbl[k].f7)) begin
                idx = k;
                fmt = tbl[k].fmt;
            end
        end
        rs1 = ins[19:15];
        rs2 = (fmt == 0) ? 5'd0 : ins[24:20];
        rd  = (fmt == 1 || fmt == 2) ? 5'd0 : ins[11:7];
        case (fmt)
            0:       imm = 32'(int'($signed(ins[31:20])));
            1:       imm = 32'(int'($signed({ins[31:25], ins[11:7]})));
            2:       imm = 32'(int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})));
            default: imm = 32'd0;
        endcase
    endtask

    task automatic compare_outputs();
        logic [34:0] one;
        logic [34:0] exp_stb;
        one = 35'd1;
        exp_stb = (exp_valid && exp_idx >= 0) ? (one << exp_idx) : 35'd0;
        check("out_valid", {63'd0, OUT_VALID}, {63'd0, exp_valid});
        check("strobes", {29'd0, got_stb}, {29'd0, exp_stb});
        if (exp_valid) begin
            check("illegal", {63'd0, ILLEGAL}, {63'd0, (exp_idx < 0)});
            check("pc_out", {32'd0, PC_OUT}, {32'd0, exp_pc});
            if (exp_idx >= 0) begin
                check("imm", {32'd0, IMM}, {32'd0, exp_imm});
                check("rs1", {59'd0, RS1_ADDR}, {59'd0, exp_rs1});
                check("rs2", {59'd0, RS2_ADDR}, {59'd0, exp_rs2});
                check("rd", {59'd0, RD_ADDR}, {59'd0, exp_rd});
            end
        end
    endtask

    // One cycle: drive at negedge, check ready, advance model, check outputs
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, input logic rst);
        INST_VALID = v; INST = ins; PC_IN = pc; OUT_READY = rdy; FLUSH = fl; RST_N = rst;
        #1;
        check("inst_ready", {63'd0, INST_READY}, {63'd0, (!exp_valid || rdy)});
        if (!rst) begin
            exp_valid = 1'b0;
        end else if (fl) begin
            exp_valid = 1'b0;
        end else if (v && (!exp_valid || rdy)) begin
            exp_valid = 1'b1;
            exp_pc = pc;
            model_decode(ins, exp_idx, exp_imm, exp_rs1, exp_rs2, exp_rd);
        end else if (rdy) begin
            exp_valid = 1'b0;
        end
        @(negedge CLK);
        compare_outputs();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int k;
        w = $urandom;
        if ($urandom_range(0, 9) < 7) begin
            k = $urandom_range(0, 34);
            w[6:0] = tbl[k].opc;
            w[14:12] = tbl[k].f3;
            if (tbl[k].f7 >= 0) w[31:25] = 7'(tbl[k].f7);
        end
        return w;
    endfunction

    initial begin
        build_table();
        @(negedge CLK);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFFF00093, 32'h40, 1'b1, 1'b0, 1'b0);
        check("rst_illegal", {63'd0, ILLEGAL}, 64'd0);
        check("rst_imm", {32'd0, IMM}, 64'd0);
        check("rst_pc", {32'd0, PC_OUT}, 64'd0);
        check("rst_addr", {49'd0, RS1_ADDR, RS2_ADDR, RD_ADDR}, 64'd0);

        step(1'b1, 32'hFFF00093, 32'h0, 1'b1, 1'b0, 1'b1);
        check("addi_stb", {63'd0, I_ADDI}, 64'd1);
        check("addi_imm", {32'd0, IMM}, 64'hFFFFFFFF);
        check("addi_rd", {59'd0, RD_ADDR}, 64'd1);
        check("addi_rs1", {59'd0, RS1_ADDR}, 64'd0);
        check("addi_ill", {63'd0, ILLEGAL}, 64'd0);

        step(1'b1, 32'h402081B3, 32'h4, 1'b1, 1'b0, 1'b1);
        check("sub_stb", {29'd0, got_stb}, 64'd1 << 10);
        check("sub_regs", {49'd0, RS1_ADDR, RS2_ADDR, RD_ADDR}, {49'd0, 5'd1, 5'd2, 5'd3});
        check("sub_imm", {32'd0, IMM}, 64'd0);

        step(1'b1, 32'hFE208EE3, 32'h100, 1'b1, 1'b0, 1'b1);
        check("beq_stb", {63'd0, I_BEQ}, 64'd1);
        check("beq_imm", {32'd0, IMM}, 64'hFFFFFFFC);
        check("beq_pc", {32'd0, PC_OUT}, 64'h100);
        check("beq_rd", {59'd0, RD_ADDR}, 64'd0);

        step(1'b1, 32'h00000000, 32'h104, 1'b1, 1'b0, 1'b1);
        check("zero_ill", {62'd0, OUT_VALID, ILLEGAL}, 64'd3);
        check("zero_stb", {29'd0, got_stb}, 64'd0);
        step(1'b1, 32'h40109093, 32'h108, 1'b1, 1'b0, 1'b1);
        check("slli_ill", {62'd0, OUT_VALID, ILLEGAL}, 64'd3);
        check("slli_stb", {29'd0, got_stb}, 64'd0);

        step(1'b1, 32'h00812087, 32'h10C, 1'b1, 1'b0, 1'b1);
`ifdef CORE_DECODE_FPU_EN
        check("flw_stb", {62'd0, I_FLW, ILLEGAL}, 64'd2);
        check("flw_imm", {32'd0, IMM}, 64'd8);
        check("flw_rs1", {59'd0, RS1_ADDR}, 64'd2);
`else
        check("flw_ill", {62'd0, I_FLW, ILLEGAL}, 64'd1);
`endif

        // Stall for three cycles, release, then flush during a second stall
        step(1'b1, 32'h002082B3, 32'h200, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0020C333, 32'h204, 1'b0, 1'b0, 1'b1);
            check("stall_hold", {63'd0, I_ADD}, 64'd1);
            check("stall_pc", {32'd0, PC_OUT}, 64'h200);
        end
        step(1'b1, 32'h0020C333, 32'h204, 1'b1, 1'b0, 1'b1);
        check("release_xor", {63'd0, I_XOR}, 64'd1);
        check("release_pc", {32'd0, PC_OUT}, 64'h204);
        step(1'b1, 32'h0020E3B3, 32'h208, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h0020E3B3, 32'h208, 1'b0, 1'b1, 1'b1);
        check("flush_valid", {63'd0, OUT_VALID}, 64'd0);

        // Reset while stalled drops the held bundle
        step(1'b1, 32'h002082B3, 32'h300, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h0020C333, 32'h304, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("rst_stall", {63'd0, OUT_VALID}, 64'd0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), rand_inst(), $urandom,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 99) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
